// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 8-bit combinational alu between two requesters,
// with latched operands and a valid/ready response channel per requester.

module alu (
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);
    always_comb begin
        y = 8'h00;
        case (op)
            4'd0:    y = a + b;
            4'd1:    y = a - b;
            4'd2:    y = a & b;
            4'd3:    y = a | b;
            4'd4:    y = a ^ b;
            4'd5:    y = (a < b) ? 8'h01 : 8'h00;
            4'd6:    y = a << b[2:0];
            4'd7:    y = a >> b[2:0];
            default: y = 8'h00;
        endcase
    end
endmodule

module alu_share_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [3:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [3:0] req1_op,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_data,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_data
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic       last;
    logic       owner;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [3:0] op_q;
    logic [7:0] result_q;
    logic [7:0] alu_y;
    logic       gnt_any;
    logic       gnt;
    logic       owner_ready;

    alu u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt     = 1'b0;
        if (req0_valid && req1_valid) gnt = ~last;
        else if (req1_valid)          gnt = 1'b1;
    end

    assign req0_ready  = (state == IDLE) && gnt_any && !gnt;
    assign req1_ready  = (state == IDLE) && gnt_any && gnt;
    assign owner_ready = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 4'h0;
            result_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        a_q   <= gnt ? req1_a  : req0_a;
                        b_q   <= gnt ? req1_b  : req0_b;
                        op_q  <= gnt ? req1_op : req0_op;
                        owner <= gnt;
                        last  <= gnt;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_y;
                    state    <= RESP;
                end
                RESP: begin
                    if (owner_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response outputs decode purely from registered state; idle lanes read 0x00.
    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign rsp0_data  = rsp0_valid ? result_q : 8'h00;
    assign rsp1_data  = rsp1_valid ? result_q : 8'h00;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level model.

module tb_alu_share_arbiter;
    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_op, req1_op;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_data, rsp1_data;

    alu_share_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: one outstanding transaction, its owner, result and age in cycles since accept.
    logic       m_busy  = 1'b0;
    logic       m_last  = 1'b1;
    logic       m_owner = 1'b0;
    logic [7:0] m_res   = 8'h00;
    int         m_age   = 0;

    logic [7:0] got0, got1;
    int         rsp_cnt = 0;
    int         grants[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int x, y, s;
        x = int'(a);
        y = int'(b);
        s = y % 8;
        case (op)
            4'd0:    return 8'((x + y) % 256);
            4'd1:    return 8'((x - y + 256) % 256);
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (x < y) ? 8'h01 : 8'h00;
            4'd6:    return 8'((x * (1 << s)) % 256);
            4'd7:    return 8'(x / (1 << s));
            default: return 8'h00;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check settled outputs, advance model to the next edge.
    task automatic cycle(input logic r,
                         input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] o0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] o1,
                         input logic rr0, input logic rr1);
        logic e_rdy0, e_rdy1, e_rv0, e_rv1, w;
        @(negedge clk);
        rst = r;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
        rsp0_ready = rr0; rsp1_ready = rr1;
        if (r) begin
            m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_age = 0;
        end
        #1;
        e_rdy0 = !m_busy && v0 && (!v1 || m_last);
        e_rdy1 = !m_busy && v1 && (!v0 || !m_last);
        e_rv0  = m_busy && (m_age >= 1) && !m_owner;
        e_rv1  = m_busy && (m_age >= 1) && m_owner;
        check("req0_ready", 8'(req0_ready), 8'(e_rdy0));
        check("req1_ready", 8'(req1_ready), 8'(e_rdy1));
        check("rsp0_valid", 8'(rsp0_valid), 8'(e_rv0));
        check("rsp1_valid", 8'(rsp1_valid), 8'(e_rv1));
        check("rsp0_data", rsp0_data, e_rv0 ? m_res : 8'h00);
        check("rsp1_data", rsp1_data, e_rv1 ? m_res : 8'h00);
        if (!r) begin
            if (req0_ready && v0) grants.push_back(0);
            if (req1_ready && v1) grants.push_back(1);
            if (rsp0_valid && rr0) begin got0 = rsp0_data; rsp_cnt++; end
            if (rsp1_valid && rr1) begin got1 = rsp1_data; rsp_cnt++; end
            if (!m_busy) begin
                if (v0 || v1) begin
                    w = (v0 && v1) ? !m_last : v1;
                    m_busy = 1'b1; m_age = 0; m_owner = w; m_last = w;
                    m_res = w ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
                end
            end else if (m_age >= 1 && (m_owner ? rr1 : rr0)) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic idle(input int n, input logic rr0, input logic rr1);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 4'h0, rr0, rr1);
    endtask

    task automatic do_reset();
        cycle(1, 0, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 4'h0, 0, 0);
        cycle(1, 1, 8'h11, 8'h22, 4'h0, 1, 8'h33, 8'h44, 4'h0, 0, 0);
    endtask

    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic [7:0] exp, input string tag);
        got1 = 8'h5A;
        cycle(0, 0, 8'h00, 8'h00, 4'h0, 1, a, b, op, 1, 1);
        idle(4, 1, 1);
        check(tag, got1, exp);
    endtask

    initial begin
        int cnt_before;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        got0 = 8'h00; got1 = 8'h00;
        do_reset();

        // Single ADD on requester 0
        got0 = 8'h5A;
        cycle(0, 1, 8'h05, 8'h03, 4'd0, 0, 8'h00, 8'h00, 4'h0, 1, 1);
        idle(4, 1, 1);
        check("add_05_03", got0, 8'h08);

        // Wrap, shift and illegal opcode on requester 1
        op1(8'h03, 8'h05, 4'd1, 8'hFE, "sub_wrap");
        op1(8'h81, 8'h09, 4'd6, 8'h02, "sll_b09");
        op1(8'hFF, 8'h01, 4'd0, 8'h00, "add_wrap");
        op1(8'h12, 8'h34, 4'hF, 8'h00, "op_illegal");

        // Both continuously valid after reset: strict alternation
        do_reset();
        grants.delete();
        for (int i = 0; i < 24; i++)
            cycle(0, 1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)),
                  1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)), 1, 1);
        idle(3, 1, 1);
        check("alt_count", 8'(grants.size()), 8'd8);
        for (int i = 0; i < 8 && i < grants.size(); i++)
            check($sformatf("alt_grant%0d", i), 8'(grants[i]), 8'(i % 2));

        // Backpressure on requester 0 with requester 1 waiting
        got0 = 8'h5A;
        cycle(0, 1, 8'hA0, 8'h0B, 4'd3, 0, 8'h00, 8'h00, 4'h0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 8'h00, 8'h00, 4'h0, 1, 8'h07, 8'h02, 4'd0, 0, 0);
        cycle(0, 0, 8'h00, 8'h00, 4'h0, 1, 8'h07, 8'h02, 4'd0, 1, 0);
        check("bp_or", got0, 8'hAB);
        cycle(0, 0, 8'h00, 8'h00, 4'h0, 1, 8'h07, 8'h02, 4'd0, 1, 1);
        idle(4, 1, 1);

        // Operand change right after accept
        got0 = 8'h5A;
        cycle(0, 1, 8'h10, 8'h01, 4'd0, 0, 8'h00, 8'h00, 4'h0, 1, 1);
        cycle(0, 0, 8'h77, 8'h55, 4'd4, 0, 8'h00, 8'h00, 4'h0, 1, 1);
        idle(3, 1, 1);
        check("operand_hold", got0, 8'h11);

        // Reset mid-EXEC and mid-RESP drop the operation
        cnt_before = rsp_cnt;
        cycle(0, 1, 8'h01, 8'h01, 4'd0, 0, 8'h00, 8'h00, 4'h0, 1, 1);
        cycle(1, 0, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 4'h0, 1, 1);
        idle(4, 1, 1);
        check("rst_exec_drop", 8'(rsp_cnt - cnt_before), 8'd0);
        cycle(0, 0, 8'h00, 8'h00, 4'h0, 1, 8'h02, 8'h02, 4'd0, 0, 0);
        idle(2, 0, 0);
        cycle(1, 0, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 4'h0, 0, 0);
        idle(4, 1, 1);
        check("rst_resp_drop", 8'(rsp_cnt - cnt_before), 8'd0);
        grants.delete();
        cycle(0, 1, 8'h03, 8'h04, 4'd2, 1, 8'h05, 8'h06, 4'd3, 1, 1);
        check("tie_after_rst", (grants.size() == 1) ? 8'(grants[0]) : 8'hEE, 8'd0);
        idle(4, 1, 1);

        // Random traffic with occasional reset
        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 99) == 0,
                  1'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                  1'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one instance of the team's 8-bit combinational `alu` between two requesters, such as a pipeline EX stage and a debug/scan port. The block arbitrates round-robin and latches operands. It runs one operation per grant and returns the registered result to the winning requester over a valid/ready response channel. It wraps `alu` unmodified: same opcode encoding and 8-bit result width.

## Interface
Parameters: none (widths fixed by `alu`: 8-bit data, 4-bit opcode).
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  requester 0 has an operation pending
- `req0_ready`  out  1  requester 0 operation accepted this edge when also valid
- `req0_a`, `req0_b`  in  8  operands A, B for requester 0
- `req0_op`  in  4  `alu` opcode for requester 0
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same for requester 1
- `rsp0_valid`  out  1  result for requester 0 available
- `rsp0_ready`  in  1  requester 0 consumes result
- `rsp0_data`  out  8  result for requester 0
- `rsp1_valid`, `rsp1_ready`, `rsp1_data`: same for requester 1

## Operation
- FSM states IDLE, EXEC, RESP; reset state IDLE.
- Priority pointer `last` (1 bit) names the requester served most recently. Reset value 1, so requester 0 wins the first tie.
- Grant is combinational in IDLE:
  - both valid: grant = ~last;
  - one valid: grant = that requester;
  - none valid: no grant.
- `reqN_ready` = (state==IDLE) && grant==N. Ready is never high outside IDLE and never high for both requesters.
- IDLE, handshake on requester g: latch `a`, `b`, `op` into operand registers, store g in `owner`, set `last`=g, go to EXEC.
- EXEC: the `alu` evaluates the operand registers. Latch its output into `result_q`, go to RESP.
- RESP: `rsp<owner>_valid`=1 and `rsp<owner>_data`=`result_q`; the other response is invalid. Hold until `rsp<owner>_ready` is sampled high, then go to IDLE.
- Inactive `rspN_data` drives 0x00. Active data is stable while valid and not ready.
- Arithmetic follows `alu` exactly:
  - 0 ADD, 1 SUB: mod 256, carry/borrow dropped;
  - 2 AND, 3 OR, 4 XOR;
  - 5 SLT: unsigned, result 0x01/0x00;
  - 6 SLL, 7 SRL: shift by B[2:0];
  - 8–15: 0x00, with no error signalled.
- Inputs of the requester that is not granted are ignored. Operands are sampled only at the accept edge, so later changes to `req*` inputs do not affect an in-flight operation.
- Reset mid-operation (any state): immediately return to IDLE, clear `rsp*_valid`, `result_q`=0x00, `owner`=0, `last`=1. The in-flight operation is dropped and no response is produced.

## Timing
- Reset values:
  - `req0_ready`=1 if `req0_valid` else 0, combinational;
  - `req1_ready`=`req1_valid` && !`req0_valid`;
  - `rsp0_valid`=`rsp1_valid`=0;
  - `rsp0_data`=`rsp1_data`=0x00.
- Accept at edge E0 → result latched at E1 → `rspN_valid` high in the cycle after E1 (one cycle between accept edge and response valid).
- With `rsp_ready` held high: response consumed at E2, IDLE after E2, next accept at E3. Peak throughput is 1 operation per 3 cycles.
- Backpressure: each extra cycle of `rsp_ready` low adds one cycle. `req*_ready` stays low throughout.
- Both requesters continuously valid: strict alternation 0,1,0,1… Worst-case wait for a valid requester is one foreign operation.
- `rspN_ready` asserted while `rspN_valid` is low has no effect.

## Test plan
- Single request: req0 ADD A=0x05 B=0x03, rsp0_ready=1 → req0_ready high at E0, rsp0_valid=1 with rsp0_data=0x08 for exactly one cycle after E1, rsp1_valid never high.
- Wrap/shift/illegal, run on requester 1:
  - SUB 0x03−0x05 → 0xFE;
  - SLL 0x81 by B=0x09 → 0x02;
  - ADD 0xFF+0x01 → 0x00;
  - op 0xF → 0x00.
- Simultaneous requests after reset, both held valid, 4 ops each → grants ordered 0,1,0,1,0,1,0,1, each response routed only to its owner with the correct data.
- Backpressure: req0 OR 0xA0|0x0B with rsp0_ready low for 5 cycles → rsp0_valid and rsp0_data=0xAB stable throughout, req0_ready and req1_ready low, completes on the edge where rsp0_ready rises.
- Operand change after accept: req0_a altered the cycle after accept → result reflects the originally latched value.
- Async reset asserted mid-EXEC and mid-RESP:
  - outputs go to reset values before the next clock edge;
  - no response is produced for the dropped operation;
  - the next tie after reset is won by requester 0.
